// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, ALU codes, operand-B encodings and the decoder control bundle
package rv_pkg;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       jump;
        logic       jumpsrc;
        logic       inv_br;
        logic       alusrc_a_zero;
        logic       hlt;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [3:0] alucontrol;
        logic [2:0] memsize;
    } ctrl_t;
endpackage

// File: rtl/rv_adder.sv
// rv_adder: wrapping WORD-bit adder
module rv_adder #(parameter int WORD = 32) (
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic [WORD-1:0] y
);
    assign y = a + b;
endmodule

// File: rtl/rv_alu.sv
// rv_alu: RV32I integer ALU, unlisted codes yield 0
import rv_pkg::*;
module rv_alu #(parameter int WORD = 32) (
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic [3:0]      op,
    output logic [WORD-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {{WORD-1{1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{WORD-1{1'b0}}, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/rv_decoder.sv
// rv_decoder: RV32I main decoder, opcode/funct fields to control bundle
import rv_pkg::*;
module rv_decoder (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output ctrl_t      ctrl
);
    logic br_ok;
    assign br_ok = funct3[2] | ~funct3[1];
    always_comb begin
        ctrl = '0;
        case (op)
            OP: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alucontrol = {funct7b5, funct3};
            end
            OP_IMM: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrcb    = SRCB_IMM;
                ctrl.alucontrol = {funct7b5 & (funct3 == 3'b101), funct3};
            end
            LOAD: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrcb  = SRCB_IMM;
                ctrl.memsize  = funct3;
            end
            STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrcb  = SRCB_IMM;
                ctrl.memsize  = funct3;
            end
            BRANCH: begin
                // funct3 010/011 are not branches and leave everything zero
                ctrl.branch     = br_ok;
                ctrl.inv_br     = br_ok & (funct3[2] ^ funct3[0]);
                ctrl.alucontrol = !br_ok ? ALU_ADD : (!funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT));
            end
            LUI: begin
                ctrl.regwrite      = 1'b1;
                ctrl.alusrc_a_zero = 1'b1;
                ctrl.alusrcb       = SRCB_IMM;
            end
            AUIPC: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrca  = 2'b01;
                ctrl.alusrcb  = SRCB_IMM;
            end
            JAL, JALR: begin
                ctrl.regwrite = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.jumpsrc  = op == JALR;
                ctrl.alusrca  = 2'b01;
                ctrl.alusrcb  = SRCB_FOUR;
            end
            SYSTEM:  ctrl.hlt = 1'b1;
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/rv_decode_execute.sv
// rv_decode_execute: RV32I decode + ALU + next-PC stage with registered outputs
import rv_pkg::*;
module rv_decode_execute #(parameter int WORD = 32) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [WORD-1:0] pc,
    input  logic [WORD-1:0] rs1_data,
    input  logic [WORD-1:0] rs2_data,
    input  logic [WORD-1:0] imm,
    output logic [WORD-1:0] aluout,
    output logic            zero,
    output logic [WORD-1:0] pcnext,
    output logic            memtoreg,
    output logic            memwrite,
    output logic            regwrite,
    output logic            branch,
    output logic            jump,
    output logic            jumpsrc,
    output logic            inv_br,
    output logic            alusrc_a_zero,
    output logic            hlt,
    output logic [1:0]      alusrcA,
    output logic [1:0]      alusrcB,
    output logic [3:0]      alucontrol,
    output logic [2:0]      memsize
);
    ctrl_t           ctrl, ctrl_q;
    logic [WORD-1:0] srca, srcb, result, pcplus4, pcbranch, jsum, pcjump;
    logic            taken;
    logic            unused;
    assign unused = ^{instr[31], instr[29:15], instr[11:7]};

    rv_decoder u_dec (.op(instr[6:0]), .funct3(instr[14:12]), .funct7b5(instr[30]), .ctrl(ctrl));

    assign srca = ctrl.alusrc_a_zero ? '0 : (ctrl.alusrca[0] ? pc : rs1_data);
    assign srcb = ctrl.alusrcb == SRCB_IMM ? imm : (ctrl.alusrcb == SRCB_FOUR ? WORD'(4) : rs2_data);

    rv_alu #(.WORD(WORD)) u_alu (.a(srca), .b(srcb), .op(ctrl.alucontrol), .y(result));

    rv_adder #(.WORD(WORD)) u_pc4 (.a(pc), .b(WORD'(4)), .y(pcplus4));
    rv_adder #(.WORD(WORD)) u_br  (.a(pc), .b(imm), .y(pcbranch));
    rv_adder #(.WORD(WORD)) u_jmp (.a(ctrl.jumpsrc ? rs1_data : pc), .b(imm), .y(jsum));

    assign pcjump = jsum & {{WORD-1{1'b1}}, 1'b0};
    assign taken  = ctrl.branch & ((result == '0) ^ ctrl.inv_br);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q <= '0;
            aluout <= '0;
            zero   <= 1'b0;
            pcnext <= '0;
        end else begin
            ctrl_q <= ctrl;
            aluout <= result;
            zero   <= result == '0;
            pcnext <= ctrl.jump ? pcjump : (taken ? pcbranch : pcplus4);
        end
    end

    assign memtoreg      = ctrl_q.memtoreg;
    assign memwrite      = ctrl_q.memwrite;
    assign regwrite      = ctrl_q.regwrite;
    assign branch        = ctrl_q.branch;
    assign jump          = ctrl_q.jump;
    assign jumpsrc       = ctrl_q.jumpsrc;
    assign inv_br        = ctrl_q.inv_br;
    assign alusrc_a_zero = ctrl_q.alusrc_a_zero;
    assign hlt           = ctrl_q.hlt;
    assign alusrcA       = ctrl_q.alusrca;
    assign alusrcB       = ctrl_q.alusrcb;
    assign alucontrol    = ctrl_q.alucontrol;
    assign memsize       = ctrl_q.memsize;
endmodule

// File: tb/tb_rv_decode_execute.sv
// tb_rv_decode_execute: directed vectors for the decode/execute stage
module tb_rv_decode_execute;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc, rs1_data, rs2_data, imm;
    logic [31:0] aluout, pcnext;
    logic        zero, memtoreg, memwrite, regwrite, branch, jump, jumpsrc, inv_br, alusrc_a_zero, hlt;
    logic [1:0]  alusrcA, alusrcB;
    logic [3:0]  alucontrol;
    logic [2:0]  memsize;
    logic [19:0] ctl;
    int          tests = 0;
    int          failed = 0;

    rv_decode_execute dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .aluout(aluout), .zero(zero), .pcnext(pcnext), .memtoreg(memtoreg),
        .memwrite(memwrite), .regwrite(regwrite), .branch(branch), .jump(jump), .jumpsrc(jumpsrc),
        .inv_br(inv_br), .alusrc_a_zero(alusrc_a_zero), .hlt(hlt), .alusrcA(alusrcA),
        .alusrcB(alusrcB), .alucontrol(alucontrol), .memsize(memsize)
    );

    always #5 clk = ~clk;

    // order: memtoreg memwrite regwrite branch jump jumpsrc inv_br alusrc_a_zero hlt | A | B | alu | memsize
    assign ctl = {memtoreg, memwrite, regwrite, branch, jump, jumpsrc, inv_br, alusrc_a_zero, hlt,
                  alusrcA, alusrcB, alucontrol, memsize};

    task automatic drive(input logic [31:0] i, p, a, b, m);
        instr = i; pc = p; rs1_data = a; rs2_data = b; imm = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(32'h40208033, 32'h1234, 32'h5, 32'h7, 32'h99);
        drive(32'h0000006F, 32'h1234, 32'h5, 32'h7, 32'h99);
        tests++; if (ctl !== 20'h0) begin failed++; $display("FAIL reset_ctl got %h want %h", ctl, 20'h0); end
        tests++; if ({aluout, pcnext, zero} !== 65'h0) begin failed++; $display("FAIL reset_data got %h %h %b want 0", aluout, pcnext, zero); end
        reset = 1'b1;
        drive(32'h00000013, 32'h100, 32'h0, 32'h0, 32'h0);
        tests++; if (pcnext !== 32'h104) begin failed++; $display("FAIL addi_pcnext got %h want %h", pcnext, 32'h104); end
        tests++; if (aluout !== 32'h0 || zero !== 1'b1) begin failed++; $display("FAIL addi_alu got %h z=%b want 0 z=1", aluout, zero); end
        tests++; if (ctl !== {9'b001000000, 2'b00, 2'b01, 4'h0, 3'h0}) begin failed++; $display("FAIL addi_ctl got %h want %h", ctl, {9'b001000000, 2'b00, 2'b01, 4'h0, 3'h0}); end
    endtask

    task automatic test_rtype;
        drive(32'h40208033, 32'h0, 32'h5, 32'h7, 32'h0);
        tests++; if (aluout !== 32'hFFFFFFFE || zero !== 1'b0) begin failed++; $display("FAIL sub_alu got %h z=%b want fffffffe z=0", aluout, zero); end
        tests++; if (ctl !== {9'b001000000, 2'b00, 2'b00, 4'h8, 3'h0}) begin failed++; $display("FAIL sub_ctl got %h want %h", ctl, {9'b001000000, 2'b00, 2'b00, 4'h8, 3'h0}); end
        drive(32'h40005033, 32'h0, 32'h80000000, 32'h4, 32'h0);
        tests++; if (aluout !== 32'hF8000000) begin failed++; $display("FAIL sra_alu got %h want %h", aluout, 32'hF8000000); end
        tests++; if (alucontrol !== 4'hD) begin failed++; $display("FAIL sra_code got %h want d", alucontrol); end
    endtask

    task automatic test_opimm;
        drive(32'h40000013, 32'h0, 32'h5, 32'h0, 32'h3);
        tests++; if (aluout !== 32'h8 || alucontrol !== 4'h0) begin failed++; $display("FAIL addi_f7_alu got %h code %h want 8 code 0", aluout, alucontrol); end
        drive(32'h40005013, 32'h0, 32'h80000000, 32'h0, 32'h404);
        tests++; if (aluout !== 32'hF8000000) begin failed++; $display("FAIL srai_alu got %h want %h", aluout, 32'hF8000000); end
        tests++; if (ctl !== {9'b001000000, 2'b00, 2'b01, 4'hD, 3'h0}) begin failed++; $display("FAIL srai_ctl got %h want %h", ctl, {9'b001000000, 2'b00, 2'b01, 4'hD, 3'h0}); end
    endtask

    task automatic test_branch;
        drive(32'h00001063, 32'h200, 32'h3, 32'h3, 32'h10);
        tests++; if (zero !== 1'b1 || inv_br !== 1'b1 || pcnext !== 32'h204) begin failed++; $display("FAIL bne_eq got z=%b inv=%b pc=%h want 1 1 204", zero, inv_br, pcnext); end
        tests++; if (ctl !== {9'b000100100, 2'b00, 2'b00, 4'h8, 3'h0}) begin failed++; $display("FAIL bne_ctl got %h want %h", ctl, {9'b000100100, 2'b00, 2'b00, 4'h8, 3'h0}); end
        drive(32'h00001063, 32'h200, 32'h3, 32'h4, 32'h10);
        tests++; if (pcnext !== 32'h210 || zero !== 1'b0) begin failed++; $display("FAIL bne_ne got pc=%h z=%b want 210 0", pcnext, zero); end
        drive(32'h00006063, 32'h300, 32'h1, 32'hFFFFFFFF, 32'h20);
        tests++; if (pcnext !== 32'h320 || aluout !== 32'h1) begin failed++; $display("FAIL bltu got pc=%h alu=%h want 320 1", pcnext, aluout); end
        tests++; if (alucontrol !== 4'h3 || inv_br !== 1'b1) begin failed++; $display("FAIL bltu_ctl got code=%h inv=%b want 3 1", alucontrol, inv_br); end
        drive(32'h00004063, 32'h300, 32'h1, 32'hFFFFFFFF, 32'h20);
        tests++; if (pcnext !== 32'h304 || aluout !== 32'h0) begin failed++; $display("FAIL blt got pc=%h alu=%h want 304 0", pcnext, aluout); end
        drive(32'h00005063, 32'h300, 32'h1, 32'hFFFFFFFF, 32'h20);
        tests++; if (pcnext !== 32'h320 || inv_br !== 1'b0) begin failed++; $display("FAIL bge got pc=%h inv=%b want 320 0", pcnext, inv_br); end
        drive(32'h00002063, 32'h300, 32'h3, 32'h3, 32'h20);
        tests++; if (ctl !== 20'h0 || pcnext !== 32'h304) begin failed++; $display("FAIL br010 got ctl=%h pc=%h want 0 304", ctl, pcnext); end
    endtask

    task automatic test_jump;
        drive(32'h00000067, 32'h40, 32'h1001, 32'h0, 32'h2);
        tests++; if (pcnext !== 32'h1002 || aluout !== 32'h44) begin failed++; $display("FAIL jalr got pc=%h alu=%h want 1002 44", pcnext, aluout); end
        tests++; if (ctl !== {9'b001011000, 2'b01, 2'b10, 4'h0, 3'h0}) begin failed++; $display("FAIL jalr_ctl got %h want %h", ctl, {9'b001011000, 2'b01, 2'b10, 4'h0, 3'h0}); end
        drive(32'h0000006F, 32'h40, 32'h1001, 32'h0, 32'hFFFFFFF8);
        tests++; if (pcnext !== 32'h38 || aluout !== 32'h44 || jumpsrc !== 1'b0 || jump !== 1'b1) begin failed++; $display("FAIL jal got pc=%h alu=%h js=%b j=%b want 38 44 0 1", pcnext, aluout, jumpsrc, jump); end
    endtask

    task automatic test_mem;
        drive(32'h00002003, 32'h80, 32'h100, 32'h55, 32'h8);
        tests++; if (aluout !== 32'h108 || ctl !== {9'b101000000, 2'b00, 2'b01, 4'h0, 3'h2}) begin failed++; $display("FAIL lw got alu=%h ctl=%h want 108 %h", aluout, ctl, {9'b101000000, 2'b00, 2'b01, 4'h0, 3'h2}); end
        drive(32'h00002023, 32'h80, 32'h100, 32'h55, 32'hFFFFFFFC);
        tests++; if (aluout !== 32'hFC || ctl !== {9'b010000000, 2'b00, 2'b01, 4'h0, 3'h2}) begin failed++; $display("FAIL sw got alu=%h ctl=%h want fc %h", aluout, ctl, {9'b010000000, 2'b00, 2'b01, 4'h0, 3'h2}); end
    endtask

    task automatic test_misc;
        drive(32'h12345037, 32'h500, 32'hDEAD, 32'h0, 32'h12345000);
        tests++; if (aluout !== 32'h12345000 || alusrc_a_zero !== 1'b1 || regwrite !== 1'b1) begin failed++; $display("FAIL lui got alu=%h az=%b rw=%b want 12345000 1 1", aluout, alusrc_a_zero, regwrite); end
        drive(32'h00000017, 32'h1000, 32'hDEAD, 32'h0, 32'h2000);
        tests++; if (aluout !== 32'h3000 || alusrcA !== 2'b01) begin failed++; $display("FAIL auipc got alu=%h A=%b want 3000 01", aluout, alusrcA); end
        drive(32'h00000073, 32'h600, 32'h1, 32'h2, 32'h3);
        tests++; if (ctl !== {9'b000000001, 11'h0} || pcnext !== 32'h604) begin failed++; $display("FAIL ecall got ctl=%h pc=%h want %h 604", ctl, pcnext, {9'b000000001, 11'h0}); end
        drive(32'h0000007F, 32'h700, 32'h1, 32'h2, 32'h3);
        tests++; if (ctl !== 20'h0 || pcnext !== 32'h704) begin failed++; $display("FAIL unknown got ctl=%h pc=%h want 0 704", ctl, pcnext); end
        reset = 1'b0;
        drive(32'h0000006F, 32'h40, 32'h0, 32'h0, 32'h8);
        tests++; if (ctl !== 20'h0 || pcnext !== 32'h0 || aluout !== 32'h0) begin failed++; $display("FAIL rereset got ctl=%h pc=%h alu=%h want 0", ctl, pcnext, aluout); end
        reset = 1'b1;
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_opimm;
        test_branch;
        test_jump;
        test_mem;
        test_misc;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/rv_decode_execute.md
Name: rv_decode_execute

Overview:
- RV32I decode-plus-execute stage: main decoder (instruction to control signals), ALU, and the PC adders (pc+4, branch target, jump target).
- Produces a registered control bundle, the ALU result, the zero flag and the next PC for the surrounding single-cycle/staged core.
- Register file, immediate generator and data memory sit outside this block.

Parameters:
- WORD, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; the port is named reset as elsewhere in the codebase, but it is active-low
- instr  in  32  current instruction
- pc  in  32  address of instr
- rs1_data  in  32  register file read port 1
- rs2_data  in  32  register file read port 2; also store data
- imm  in  32  sign-extended immediate from the external immSel
- aluout  out  32  registered ALU result
- zero  out  1  registered flag, 1 when the ALU result is 0
- pcnext  out  32  registered next PC
- memtoreg, memwrite, regwrite, branch, jump, jumpsrc, inv_br, alusrc_a_zero, hlt  out  1 each  registered decoder controls
- alusrcA  out  2  bit0: 1 selects pc, 0 selects rs1; bit1 is always 0
- alusrcB  out  2  0 selects rs2, 1 selects imm, 2 selects constant 4
- alucontrol  out  4  registered ALU operation code
- memsize  out  3  registered funct3 for loads/stores, 0 otherwise

Behaviour:
- All combinational logic is evaluated from the current inputs. Every output is registered, so latency is 1 cycle.
- When reset==0 at a rising edge, every output becomes 0. No handshake.
- Field extraction: op=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
- ALU codes, {funct7[5],funct3} style:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - Shifts use b[4:0]. SLT compares signed; SLTU compares unsigned.
  - Results are 32-bit and wrap with no overflow flag.
  - Any unlisted code yields 0.
- Operand selection:
  - srca = 0 if alusrc_a_zero; else pc if alusrcA[0]; else rs1_data.
  - srcb follows alusrcB as listed in Ports.
- Decode by opcode (any control not listed is 0):
  - OP 0110011: regwrite; ALU code {funct7[5],funct3}.
  - OP-IMM 0010011: regwrite, alusrcB=1; ALU code {funct7[5]&(funct3==101),funct3}, i.e. SUB is never produced.
  - LOAD 0000011: regwrite, memtoreg, alusrcB=1, ADD, memsize=funct3.
  - STORE 0100011: memwrite, alusrcB=1, ADD, memsize=funct3.
  - BRANCH 1100011: branch, alusrcB=0. Mapping by funct3:
    - BEQ (000): SUB, inv_br=0. BNE (001): SUB, inv_br=1.
    - BLT (100): SLT, inv_br=1. BGE (101): SLT, inv_br=0.
    - BLTU (110): SLTU, inv_br=1. BGEU (111): SLTU, inv_br=0.
    - funct3 010/011 decode as all-zero controls (no branch).
  - LUI 0110111: regwrite, alusrc_a_zero, alusrcB=1, ADD.
  - AUIPC 0010111: regwrite, alusrcA=01, alusrcB=1, ADD.
  - JAL 1101111: regwrite, jump, alusrcA=01, alusrcB=2, ADD (link = pc+4).
  - JALR 1100111: regwrite, jump, jumpsrc, alusrcA=01, alusrcB=2, ADD.
  - SYSTEM 1110011: hlt=1, all other controls 0.
  - Any other opcode: all controls 0, which behaves as a NOP.
- Next PC:
  - pcplus4 = pc+4; pcbranch = pc+imm.
  - jmp = ((jumpsrc ? rs1_data : pc) + imm) & ~1.
  - taken = branch & (zero_comb ^ inv_br).
  - pcnext = jump ? jmp : (taken ? pcbranch : pcplus4). All sums wrap modulo 2^32.
- hlt is only a registered flag; stopping simulation is the caller's job.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM;
  - ALU code constants: ALU_ADD … ALU_AND;
  - alusrcB encodings: SRCB_RS2, SRCB_IMM, SRCB_FOUR.
- Sub-modules: rv_decoder (combinational controls), rv_alu (combinational) and a generic rv_adder instantiated three times.
- The top module holds the operand muxes, next-PC logic and output registers.

Test Plan:
- Reset: reset=0 for 2 cycles with an arbitrary instr -> all outputs 0. Release, then apply instr=0x00000013 (addi x0,x0,0), pc=0x100 -> next cycle pcnext=0x104, regwrite=1, aluout=0.
- R-type SUB and SRA: instr=0x40208033 (sub), rs1=5, rs2=7 -> aluout=0xFFFFFFFE, zero=0. SRA with rs1=0x80000000, rs2=4 -> aluout=0xF8000000.
- BNE: pc=0x200, imm=0x10, rs1=rs2=3 -> zero=1, inv_br=1, pcnext=0x204. With rs2=4 -> pcnext=0x210.
- BLTU with rs1=1, rs2=0xFFFFFFFF -> taken, pcnext=pc+imm. BLT with the same operands -> not taken.
- JALR: rs1=0x1001, imm=2, pc=0x40 -> pcnext=0x1002, aluout=0x44, jump=1, jumpsrc=1. JAL imm=-8, pc=0x40 -> pcnext=0x38.
- LUI 0x12345 with rs1_data=0xDEAD -> aluout=0x12345000. instr=0x00000073 (ecall) -> hlt=1, regwrite=0. Unknown opcode 0x7F -> all controls 0, pcnext=pc+4.
